smi_responder: RTL and testbench

SMI_RESPONDER -- requirements
Module: smi_responder

---
 rtl/smi_pkg.sv | 31 +++
 rtl/smi_sync_edge.sv | 35 +++
 rtl/smi_responder.sv | 255 +++++++++++++++++++++++++
 tb/tb_smi_responder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smi_pkg.sv
// Shared definitions for the SMI (MDIO) responder: FSM states, opcodes,
// register addresses and register constants.
package smi_pkg;

    typedef enum logic [3:0] {
        S_PRE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RD_DATA,
        S_WR_DATA,
        S_SKIP
    } smi_state_e;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_BMCR    = 5'd0;
    localparam logic [4:0] REG_BMSR    = 5'd1;
    localparam logic [4:0] REG_ID1     = 5'd2;
    localparam logic [4:0] REG_ID2     = 5'd3;
    localparam logic [4:0] REG_PHYSTAT = 5'd17;

    localparam logic [15:0] BMCR_RESET = 16'h1140;
    localparam logic [15:0] BMSR_BASE  = 16'h7949;
    // BMCR bits 15 (reset) and 9 (restart AN) act as strobes, never stored.
    localparam logic [15:0] BMCR_SC_MASK = 16'h8200;

endpackage

// File: rtl/smi_sync_edge.sv
// Two-flop synchronisers for MDC and MDIO plus an MDC rising-edge strobe.
// Ports:
//   clk, rst_n      - system clock, synchronous active-low reset
//   mdc_i, mdio_i   - asynchronous management clock / data inputs
//   mdc_rise_o      - one-clk pulse per synchronised MDC rising edge
//   mdio_s_o        - synchronised MDIO, aligned with mdc_rise_o
module smi_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc_i,
    input  logic mdio_i,
    output logic mdc_rise_o,
    output logic mdio_s_o
);

    logic [1:0] mdc_q;
    logic [1:0] mdio_q;
    logic       mdc_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mdc_q      <= 2'b11;
            mdio_q     <= 2'b11;
            mdc_prev_q <= 1'b1;
        end else begin
            mdc_q      <= {mdc_q[0], mdc_i};
            mdio_q     <= {mdio_q[0], mdio_i};
            mdc_prev_q <= mdc_q[1];
        end
    end

    assign mdc_rise_o = mdc_q[1] & ~mdc_prev_q;
    assign mdio_s_o   = mdio_q[1];

endmodule

// File: rtl/smi_responder.sv
// Clause-22 style MDIO management responder with a small register map
// (BMCR, BMSR, PHY IDs, PHY status at reg 17).
// Ports:
//   clk, rst_n          - system clock (>= 8x MDC), synchronous active-low reset
//   mdc, mdio_i         - management clock and sampled MDIO line
//   mdio_o, mdio_oe     - MDIO drive value / enable for the top-level pad
//   link_up, speed      - live status reported through BMSR and reg 17
//   bmcr                - current control register
//   sw_reset, an_restart- one-clk strobes from BMCR bits 15 / 9
//
// state     | meaning
// S_PRE     | counting preamble ones
// S_ST      | expecting second start bit (1)
// S_OP      | collecting 2-bit opcode
// S_PHYAD   | shifting in PHY address
// S_REGAD   | shifting in register address
// S_TA      | turnaround; read latches data and starts driving 0
// S_RD_DATA | driving 16 read data bits
// S_WR_DATA | shifting in 16 write data bits
// S_SKIP    | frame for another PHY, waiting out TA + data
module smi_responder
    import smi_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h001C,
    parameter logic [15:0] PHY_ID2  = 16'hC915,
    parameter int          PRE_MIN  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_up,
    input  logic [1:0]  speed,
    output logic [15:0] bmcr,
    output logic        sw_reset,
    output logic        an_restart
);

    localparam int            PW      = $clog2(PRE_MIN + 1);
    localparam logic [PW-1:0] PRE_SAT = PW'(PRE_MIN);

    smi_state_e    state_q, state_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic [4:0]    regad_q, regad_d;
    logic          is_read_q, is_read_d;
    logic          phy_match_q, phy_match_d;
    logic          mdio_o_q, mdio_o_d;
    logic          mdio_oe_q, mdio_oe_d;
    logic [15:0]   bmcr_q, bmcr_d;
    logic          sw_reset_q, sw_reset_d;
    logic          an_restart_q, an_restart_d;

    logic          mdc_rise;
    logic          mdio_s;
    logic [15:0]   sh_in;
    logic [15:0]   rd_value;

    smi_sync_edge u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdc_i      (mdc),
        .mdio_i     (mdio_i),
        .mdc_rise_o (mdc_rise),
        .mdio_s_o   (mdio_s)
    );

    assign sh_in = {shift_q[14:0], mdio_s};

    always_comb begin
        rd_value = 16'h0000;
        case (regad_q)
            REG_BMCR:    rd_value = bmcr_q;
            REG_BMSR:    rd_value = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
            REG_ID1:     rd_value = PHY_ID1;
            REG_ID2:     rd_value = PHY_ID2;
            REG_PHYSTAT: rd_value = {speed, 1'b1, 1'b1, link_up, 11'd0};
            default:     rd_value = 16'h0000;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        regad_d      = regad_q;
        is_read_d    = is_read_q;
        phy_match_d  = phy_match_q;
        mdio_o_d     = mdio_o_q;
        mdio_oe_d    = mdio_oe_q;
        bmcr_d       = bmcr_q;
        sw_reset_d   = 1'b0;
        an_restart_d = 1'b0;

        if (mdc_rise) begin
            case (state_q)
                S_PRE: begin
                    if (mdio_s) begin
                        if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + PW'(1);
                    end else begin
                        // count saturates at PRE_SAT, so equality means ">= PRE_MIN"
                        if (pre_cnt_q == PRE_SAT) state_d = S_ST;
                        pre_cnt_d = '0;
                    end
                end
                S_ST: begin
                    bit_cnt_d = 5'd0;
                    state_d   = mdio_s ? S_OP : S_PRE;
                end
                S_OP: begin
                    shift_d = sh_in;
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                    end else begin
                        bit_cnt_d = 5'd0;
                        if (sh_in[1:0] == OP_READ) begin
                            is_read_d = 1'b1;
                            state_d   = S_PHYAD;
                        end else if (sh_in[1:0] == OP_WRITE) begin
                            is_read_d = 1'b0;
                            state_d   = S_PHYAD;
                        end else begin
                            state_d = S_PRE;
                        end
                    end
                end
                S_PHYAD: begin
                    shift_d = sh_in;
                    if (bit_cnt_q == 5'd4) begin
                        phy_match_d = (sh_in[4:0] == PHY_ADDR);
                        bit_cnt_d   = 5'd0;
                        state_d     = S_REGAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_REGAD: begin
                    shift_d = sh_in;
                    if (bit_cnt_q == 5'd4) begin
                        regad_d   = sh_in[4:0];
                        bit_cnt_d = 5'd0;
                        state_d   = phy_match_q ? S_TA : S_SKIP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_TA: begin
                    if (bit_cnt_q == 5'd0) begin
                        bit_cnt_d = 5'd1;
                        if (is_read_q) begin
                            // snapshot of live status so the frame stays coherent
                            shift_d   = rd_value;
                            mdio_oe_d = 1'b1;
                            mdio_o_d  = 1'b0;
                        end
                    end else begin
                        bit_cnt_d = 5'd0;
                        if (is_read_q) begin
                            mdio_o_d = shift_q[15];
                            shift_d  = {shift_q[14:0], 1'b0};
                            state_d  = S_RD_DATA;
                        end else begin
                            state_d = S_WR_DATA;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d = 5'd0;
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b1;
                        state_d   = S_PRE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        mdio_o_d  = shift_q[15];
                        shift_d   = {shift_q[14:0], 1'b0};
                    end
                end
                S_WR_DATA: begin
                    shift_d = sh_in;
                    if (bit_cnt_q == 5'd15) begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_PRE;
                        if (regad_q == REG_BMCR) begin
                            if (sh_in[15]) begin
                                sw_reset_d = 1'b1;
                                bmcr_d     = BMCR_RESET;
                            end else begin
                                bmcr_d       = sh_in & ~BMCR_SC_MASK;
                                an_restart_d = sh_in[9];
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                S_SKIP: begin
                    if (bit_cnt_q == 5'd17) begin
                        bit_cnt_d = 5'd0;
                        state_d   = S_PRE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d   = S_PRE;
                    pre_cnt_d = '0;
                    bit_cnt_d = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_PRE;
            pre_cnt_q    <= '0;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 16'h0000;
            regad_q      <= 5'd0;
            is_read_q    <= 1'b0;
            phy_match_q  <= 1'b0;
            mdio_o_q     <= 1'b1;
            mdio_oe_q    <= 1'b0;
            bmcr_q       <= BMCR_RESET;
            sw_reset_q   <= 1'b0;
            an_restart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            regad_q      <= regad_d;
            is_read_q    <= is_read_d;
            phy_match_q  <= phy_match_d;
            mdio_o_q     <= mdio_o_d;
            mdio_oe_q    <= mdio_oe_d;
            bmcr_q       <= bmcr_d;
            sw_reset_q   <= sw_reset_d;
            an_restart_q <= an_restart_d;
        end
    end

    assign mdio_o     = mdio_o_q;
    assign mdio_oe    = mdio_oe_q;
    assign bmcr       = bmcr_q;
    assign sw_reset   = sw_reset_q;
    assign an_restart = an_restart_q;

endmodule

// File: tb/tb_smi_responder.sv
// Self-checking bench for smi_responder: a station model bit-bangs MDC/MDIO
// frames and results are compared with a register-map model.
module tb_smi_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdc;
    logic        drv;
    logic        link_up;
    logic [1:0]  speed;
    wire         mdio_o;
    wire         mdio_oe;
    wire  [15:0] bmcr;
    wire         sw_reset;
    wire         an_restart;
    wire         mdio_line = mdio_oe ? mdio_o : drv;

    always #5 clk = ~clk;

    smi_responder #(
        .PHY_ADDR (5'd1),
        .PHY_ID1  (16'h001C),
        .PHY_ID2  (16'hC915),
        .PRE_MIN  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mdc        (mdc),
        .mdio_i     (mdio_line),
        .mdio_o     (mdio_o),
        .mdio_oe    (mdio_oe),
        .link_up    (link_up),
        .speed      (speed),
        .bmcr       (bmcr),
        .sw_reset   (sw_reset),
        .an_restart (an_restart)
    );

    int checks = 0;
    int passed = 0;
    int sw_cnt = 0;
    int an_cnt = 0;

    // pulse high-cycles; a one-clk pulse counts exactly once
    always @(negedge clk) begin
        if (sw_reset)   sw_cnt++;
        if (an_restart) an_cnt++;
    end

    // ---------------- reference model ----------------
    logic [15:0] m_bmcr;
    int          exp_sw;
    int          exp_an;

    function automatic logic [15:0] model_read(input logic [4:0] r);
        case (r)
            5'd0:    return m_bmcr;
            5'd1:    return 16'h7949 + (link_up ? 16'd4 : 16'd0);
            5'd2:    return 16'h001C;
            5'd3:    return 16'hC915;
            5'd17:   return 16'(speed * 16384 + 8192 + 4096 + (link_up ? 2048 : 0));
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_write(input logic [4:0] phy, input logic [4:0] r, input logic [15:0] d);
        if (phy == 5'd1 && r == 5'd0) begin
            if (d[15]) begin
                exp_sw++;
                m_bmcr = 16'h1140;
            end else begin
                m_bmcr = d & 16'h7DFF;
                if (d[9]) exp_an++;
            end
        end
    endtask

    // ---------------- station model ----------------
    logic [15:0] f_rdata;
    logic [31:0] f_oe;
    logic        f_ta2;
    logic        f_pre_oe;
    logic        f_end_oe;

    task automatic mdc_bit(input logic b, output logic line, output logic oe);
        mdc = 1'b0;
        drv = b;
        repeat (8) @(negedge clk);
        line = mdio_line;
        oe   = mdio_oe;
        mdc  = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_frame(input int pre_len, input logic rd, input logic [4:0] phy,
                            input logic [4:0] r, input logic [15:0] wdata,
                            input int flip_pos, input int stop_at);
        logic [31:0] bits;
        logic        l, o;
        bits     = {2'b01, (rd ? 2'b10 : 2'b01), phy, r, (rd ? 2'b11 : 2'b10),
                    (rd ? 16'hFFFF : wdata)};
        f_rdata  = 16'h0000;
        f_oe     = 32'h0;
        f_ta2    = 1'b1;
        f_pre_oe = 1'b0;
        for (int i = 0; i < pre_len; i++) begin
            mdc_bit(1'b1, l, o);
            if (o) f_pre_oe = 1'b1;
        end
        for (int i = 0; i < 32 && i < stop_at; i++) begin
            if (i == flip_pos) link_up = ~link_up;
            mdc_bit(bits[31-i], l, o);
            f_oe[31-i] = o;
            if (i == 15) f_ta2 = l;
            if (i >= 16) f_rdata[31-i] = l;
        end
        if (stop_at >= 32) begin
            mdc = 1'b0;
            drv = 1'b1;
            repeat (4) @(negedge clk);
            f_end_oe = mdio_oe;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; mdc = 1'b0; drv = 1'b1; link_up = 1'b0; speed = 2'b00;
        m_bmcr = 16'h1140; exp_sw = 0; exp_an = 0;
        repeat (4) @(negedge clk);
        checks++;
        if ({mdio_oe, mdio_o, sw_reset, an_restart} !== 4'b0100)
            $display("FAIL reset_outputs: got oe/o/sw/an=%b required 0100",
                     {mdio_oe, mdio_o, sw_reset, an_restart});
        else passed++;
        checks++;
        if (bmcr !== 16'h1140) $display("FAIL reset_bmcr: got %h required 1140", bmcr);
        else passed++;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_read_phystat();
        logic [15:0] exp;
        link_up = 1'b1; speed = 2'b10;
        exp = model_read(5'd17);
        do_frame(32, 1'b1, 5'd1, 5'd17, 16'h0, -1, 32);
        checks++;
        if (f_rdata !== exp) $display("FAIL phystat_data: got %h required %h", f_rdata, exp);
        else passed++;
        checks++;
        if (f_oe !== 32'h0001FFFF || f_ta2 !== 1'b0 || f_end_oe !== 1'b0 || f_pre_oe !== 1'b0)
            $display("FAIL phystat_drive: oe=%h ta2=%b end_oe=%b pre_oe=%b required 0001ffff/0/0/0",
                     f_oe, f_ta2, f_end_oe, f_pre_oe);
        else passed++;
    endtask

    task automatic test_write_restart();
        int sw0, an0;
        sw0 = sw_cnt; an0 = an_cnt;
        model_write(5'd1, 5'd0, 16'h1340);
        do_frame(32, 1'b0, 5'd1, 5'd0, 16'h1340, -1, 32);
        checks++;
        if (an_cnt - an0 !== 1 || sw_cnt - sw0 !== 0)
            $display("FAIL restart_pulses: got an=%0d sw=%0d required 1/0", an_cnt - an0, sw_cnt - sw0);
        else passed++;
        checks++;
        if (bmcr !== m_bmcr || f_oe !== 32'h0)
            $display("FAIL restart_bmcr: got %h oe=%h required %h oe=0", bmcr, f_oe, m_bmcr);
        else passed++;
        do_frame(32, 1'b1, 5'd1, 5'd0, 16'h0, -1, 32);
        checks++;
        if (f_rdata !== 16'h1140) $display("FAIL restart_readback: got %h required 1140", f_rdata);
        else passed++;
    endtask

    task automatic test_wrong_phy();
        logic [15:0] exp;
        do_frame(32, 1'b1, 5'd2, 5'd1, 16'h0, -1, 32);
        checks++;
        if (f_oe !== 32'h0 || f_end_oe !== 1'b0)
            $display("FAIL wrong_phy_oe: got oe=%h end=%b required 0", f_oe, f_end_oe);
        else passed++;
        exp = model_read(5'd1);
        do_frame(32, 1'b1, 5'd1, 5'd1, 16'h0, -1, 32);
        checks++;
        if (f_rdata !== exp || f_oe !== 32'h0001FFFF)
            $display("FAIL after_wrong_phy: got %h oe=%h required %h", f_rdata, f_oe, exp);
        else passed++;
    endtask

    task automatic test_preamble();
        logic [15:0] exp;
        exp = model_read(5'd2);
        do_frame(31, 1'b1, 5'd1, 5'd2, 16'h0, -1, 32);
        checks++;
        if (f_oe !== 32'h0) $display("FAIL preamble_31: got oe=%h required 0", f_oe);
        else passed++;
        do_frame(32, 1'b1, 5'd1, 5'd2, 16'h0, -1, 32);
        checks++;
        if (f_rdata !== exp || f_oe !== 32'h0001FFFF)
            $display("FAIL preamble_32: got %h oe=%h required %h", f_rdata, f_oe, exp);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_frame(32, 1'b1, 5'd1, 5'd3, 16'h0, -1, 32);
        do_frame(0, 1'b1, 5'd1, 5'd3, 16'h0, -1, 32);
        checks++;
        if (f_oe !== 32'h0) $display("FAIL back_to_back: got oe=%h required 0", f_oe);
        else passed++;
    endtask

    task automatic test_sw_reset();
        int sw0, an0;
        model_write(5'd1, 5'd0, 16'h0100);
        do_frame(32, 1'b0, 5'd1, 5'd0, 16'h0100, -1, 32);
        checks++;
        if (bmcr !== m_bmcr) $display("FAIL bmcr_write: got %h required %h", bmcr, m_bmcr);
        else passed++;
        sw0 = sw_cnt; an0 = an_cnt;
        model_write(5'd1, 5'd0, 16'h8000);
        do_frame(32, 1'b0, 5'd1, 5'd0, 16'h8000, -1, 32);
        checks++;
        if (sw_cnt - sw0 !== 1 || an_cnt - an0 !== 0 || bmcr !== 16'h1140)
            $display("FAIL sw_reset: got sw=%0d an=%0d bmcr=%h required 1/0/1140",
                     sw_cnt - sw0, an_cnt - an0, bmcr);
        else passed++;
    endtask

    task automatic test_link_mid_frame();
        logic [15:0] exp;
        link_up = 1'b1;
        exp = model_read(5'd1);
        do_frame(32, 1'b1, 5'd1, 5'd1, 16'h0, 24, 32);
        checks++;
        if (f_rdata !== exp) $display("FAIL link_snapshot: got %h required %h", f_rdata, exp);
        else passed++;
    endtask

    task automatic test_random();
        logic        rd;
        logic [4:0]  phy, r;
        logic [15:0] d, exp;
        int          sw0, an0;
        for (int n = 0; n < 30; n++) begin
            rd      = 1'($urandom_range(0, 1));
            phy     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
            link_up = 1'($urandom_range(0, 1));
            speed   = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0, 1:    r = 5'd0;
                2:       r = 5'd1;
                3:       r = 5'd2;
                4:       r = 5'd3;
                5:       r = 5'd17;
                6:       r = 5'($urandom_range(4, 16));
                default: r = 5'($urandom_range(18, 31));
            endcase
            d = 16'($urandom);
            if (d[15]) d[9] = 1'b0;
            sw0 = sw_cnt; an0 = an_cnt;
            exp_sw = 0; exp_an = 0;
            if (rd) begin
                exp = model_read(r);
                do_frame(32, 1'b1, phy, r, 16'h0, -1, 32);
                checks++;
                if (phy == 5'd1 && (f_rdata !== exp || f_oe !== 32'h0001FFFF || f_ta2 !== 1'b0))
                    $display("FAIL rand_read[%0d]: reg %0d got %h oe=%h required %h", n, r, f_rdata, f_oe, exp);
                else if (phy != 5'd1 && f_oe !== 32'h0)
                    $display("FAIL rand_read[%0d]: phy %0d got oe=%h required 0", n, phy, f_oe);
                else passed++;
            end else begin
                model_write(phy, r, d);
                do_frame(32, 1'b0, phy, r, d, -1, 32);
                checks++;
                if (bmcr !== m_bmcr || sw_cnt - sw0 !== exp_sw || an_cnt - an0 !== exp_an || f_oe !== 32'h0)
                    $display("FAIL rand_write[%0d]: reg %0d d=%h got bmcr=%h sw=%0d an=%0d required %h/%0d/%0d",
                             n, r, d, bmcr, sw_cnt - sw0, an_cnt - an0, m_bmcr, exp_sw, exp_an);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid_read();
        model_write(5'd1, 5'd0, 16'h2100);
        do_frame(32, 1'b0, 5'd1, 5'd0, 16'h2100, -1, 32);
        do_frame(32, 1'b1, 5'd1, 5'd0, 16'h0, -1, 22);
        checks++;
        if (mdio_oe !== 1'b1) $display("FAIL mid_read_driving: got oe=%b required 1", mdio_oe);
        else passed++;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (mdio_oe !== 1'b0) $display("FAIL reset_release_oe: got oe=%b required 0", mdio_oe);
        else passed++;
        mdc = 1'b0; drv = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_bmcr = 16'h1140;
        repeat (4) @(negedge clk);
        do_frame(32, 1'b1, 5'd1, 5'd0, 16'h0, -1, 32);
        checks++;
        if (f_rdata !== m_bmcr || f_oe !== 32'h0001FFFF)
            $display("FAIL after_reset_read: got %h oe=%h required %h", f_rdata, f_oe, m_bmcr);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_read_phystat();
        test_write_restart();
        test_wrong_phy();
        test_preamble();
        test_back_to_back();
        test_sw_reset();
        test_link_mid_frame();
        test_random();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
